// File: rtl/csr_commit_queue.sv
// csr_commit_queue
//   In-order buffer for CSR instructions between issue and commit. Issue pushes
//   {addr, op, operand}; the scoreboard gets an immediate writeback echo of the
//   operand. The CSR file performs the head operation when commit retires it.
//   flush_i discards every uncommitted entry after letting a same-cycle commit
//   complete.
//   Optional feature: define CSR_COMMIT_QUEUE_OCCUPANCY_EN to add occupancy_o
//   (current count) and max_occupancy_o (sticky high-water mark).
module csr_commit_queue #(
    parameter int DEPTH         = 2,
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [TRANS_ID_BITS-1:0]   trans_id_i,
    input  logic [11:0]                csr_addr_i,
    input  logic [7:0]                 csr_op_i,
    input  logic [XLEN-1:0]            operand_i,
    output logic                       result_valid_o,
    output logic [TRANS_ID_BITS-1:0]   result_trans_id_o,
    output logic [XLEN-1:0]            result_o,
    input  logic                       commit_i,
    output logic                       commit_ready_o,
    output logic                       csr_valid_o,
    output logic [11:0]                csr_addr_o,
    output logic [7:0]                 csr_op_o,
    output logic [XLEN-1:0]            csr_wdata_o,
    output logic                       commit_err_o
`ifdef CSR_COMMIT_QUEUE_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic [$clog2(DEPTH+1)-1:0] max_occupancy_o
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [11:0]     addr;
        logic [7:0]      op;
        logic [XLEN-1:0] operand;
    } entry_t;

    entry_t                   r_mem [DEPTH];
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [CNT_W-1:0]         r_count;
    logic                     r_result_valid;
    logic [TRANS_ID_BITS-1:0] r_result_trans_id;
    logic [XLEN-1:0]          r_result;
    logic                     r_commit_err;

    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic [CNT_W-1:0]         w_count_next;
    entry_t                   w_head;

    // Wrap a pointer from DEPTH-1 back to 0 (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_empty = (r_count == '0);

    // Acceptance never looks at commit_i, so a full queue refuses a push even
    // in the cycle its head retires.
    assign ready_o = !rst_i && !flush_i && (r_count < DEPTH_C);
    assign w_push  = valid_i && ready_o;
    assign w_pop   = !rst_i && commit_i && !w_empty;

    assign w_head         = r_mem[r_rd_ptr];
    assign commit_ready_o = !w_empty;
    assign csr_valid_o    = w_pop;
    assign csr_addr_o     = w_empty ? '0 : w_head.addr;
    assign csr_op_o       = w_empty ? '0 : w_head.op;
    assign csr_wdata_o    = w_empty ? '0 : w_head.operand;

    assign result_valid_o    = r_result_valid;
    assign result_trans_id_o = r_result_trans_id;
    assign result_o          = r_result;
    assign commit_err_o      = r_commit_err;

    // Next occupancy: flush empties the queue; otherwise push/pop adjust by one.
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        w_count_next = r_count;
        if (flush_i) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // Pointer and count state; flush returns both pointers to slot 0.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= w_count_next;
            if (flush_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
                if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

    // Entry storage written on push.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is deliberately not reset; the count gates every read, so stale slots never reach an output.
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{addr: csr_addr_i, op: csr_op_i, operand: operand_i};
        end
    end

    // Writeback echo one cycle after a push, and the empty-commit error pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result_valid    <= 1'b0;
            r_result_trans_id <= '0;
            r_result          <= '0;
            r_commit_err      <= 1'b0;
        end else begin
            // A flush blocks the push, so no writeback is pending after it.
            r_result_valid    <= w_push;
            r_result_trans_id <= w_push ? trans_id_i : '0;
            r_result          <= w_push ? operand_i : '0;
            r_commit_err      <= commit_i && w_empty;
        end
    end

`ifdef CSR_COMMIT_QUEUE_OCCUPANCY_EN
    logic [CNT_W-1:0] r_max_occupancy;

    assign occupancy_o     = r_count;
    assign max_occupancy_o = r_max_occupancy;

    // Sticky high-water mark of the count, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_max_occupancy <= '0;
        end else if (w_count_next > r_max_occupancy) begin
            r_max_occupancy <= w_count_next;
        end
    end
`endif

endmodule

// File: tb/tb_csr_commit_queue.sv
// tb_csr_commit_queue
//   Directed literal scenarios followed by randomized traffic, with a queue-based
//   reference model compared against every DUT output on each falling edge.
module tb_csr_commit_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 64;
    localparam int TIDW  = 3;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [TIDW-1:0] trans_id_i;
    logic [11:0]     csr_addr_i;
    logic [7:0]      csr_op_i;
    logic [XLEN-1:0] operand_i;
    logic            result_valid_o;
    logic [TIDW-1:0] result_trans_id_o;
    logic [XLEN-1:0] result_o;
    logic            commit_i;
    logic            commit_ready_o;
    logic            csr_valid_o;
    logic [11:0]     csr_addr_o;
    logic [7:0]      csr_op_o;
    logic [XLEN-1:0] csr_wdata_o;
    logic            commit_err_o;
`ifdef CSR_COMMIT_QUEUE_OCCUPANCY_EN
    logic [1:0]      occupancy_o;
    logic [1:0]      max_occupancy_o;
`endif

    int n_pass  = 0;
    int n_total = 0;

    csr_commit_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .TRANS_ID_BITS(TIDW)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .trans_id_i        (trans_id_i),
        .csr_addr_i        (csr_addr_i),
        .csr_op_i          (csr_op_i),
        .operand_i         (operand_i),
        .result_valid_o    (result_valid_o),
        .result_trans_id_o (result_trans_id_o),
        .result_o          (result_o),
        .commit_i          (commit_i),
        .commit_ready_o    (commit_ready_o),
        .csr_valid_o       (csr_valid_o),
        .csr_addr_o        (csr_addr_o),
        .csr_op_o          (csr_op_o),
        .csr_wdata_o       (csr_wdata_o),
        .commit_err_o      (commit_err_o)
`ifdef CSR_COMMIT_QUEUE_OCCUPANCY_EN
        ,
        .occupancy_o       (occupancy_o),
        .max_occupancy_o   (max_occupancy_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [11:0] addr;
        logic [7:0]  op;
        logic [63:0] data;
    } ent_t;

    ent_t        mdl_q[$];
    bit          mdl_init = 0;
    logic        exp_rv;
    logic [63:0] exp_rid;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          mdl_max;

    always @(posedge clk_i) begin
        if (rst_i) begin
            mdl_q.delete();
            exp_rv    = 0;
            exp_rid   = 0;
            exp_rdata = 0;
            exp_err   = 0;
            mdl_max   = 0;
            mdl_init  = 1;
        end else if (mdl_init) begin
            automatic int  n    = mdl_q.size();
            automatic bit  push = valid_i && !flush_i && (n < DEPTH);
            automatic bit  pop  = commit_i && (n > 0);
            automatic ent_t e;
            e.addr = csr_addr_i;
            e.op   = csr_op_i;
            e.data = operand_i;
            exp_err   = commit_i && (n == 0);
            exp_rv    = push;
            exp_rid   = push ? 64'(trans_id_i) : 64'd0;
            exp_rdata = push ? operand_i : 64'd0;
            if (pop) void'(mdl_q.pop_front());
            if (flush_i) mdl_q.delete();
            else if (push) mdl_q.push_back(e);
            if (mdl_q.size() > mdl_max) mdl_max = mdl_q.size();
        end
    end

    // Single compare process: every output against the model, mid-cycle.
    always @(negedge clk_i) begin
        if (mdl_init) begin
            automatic int n = mdl_q.size();
            check("ready_o", ready_o, !rst_i && !flush_i && (n < DEPTH));
            check("commit_ready_o", commit_ready_o, n != 0);
            check("csr_valid_o", csr_valid_o, !rst_i && commit_i && (n != 0));
            check("csr_addr_o", csr_addr_o, (n != 0) ? 64'(mdl_q[0].addr) : 64'd0);
            check("csr_op_o", csr_op_o, (n != 0) ? 64'(mdl_q[0].op) : 64'd0);
            check("csr_wdata_o", csr_wdata_o, (n != 0) ? mdl_q[0].data : 64'd0);
            check("result_valid_o", result_valid_o, exp_rv);
            check("result_trans_id_o", result_trans_id_o, exp_rid);
            check("result_o", result_o, exp_rdata);
            check("commit_err_o", commit_err_o, exp_err);
`ifdef CSR_COMMIT_QUEUE_OCCUPANCY_EN
            check("occupancy_o", occupancy_o, 64'(n));
            check("max_occupancy_o", max_occupancy_o, 64'(mdl_max));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [TIDW-1:0] id, input logic [11:0] a,
                         input logic [7:0] op, input logic [63:0] d,
                         input logic c, input logic f);
        valid_i    = v;
        trans_id_i = id;
        csr_addr_i = a;
        csr_op_i   = op;
        operand_i  = d;
        commit_i   = c;
        flush_i    = f;
    endtask

    task automatic idle();
        drive(0, '0, 12'h0, 8'h0, 64'h0, 0, 0);
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        nxt();
        nxt();
        rst_i = 1'b0;

        // Post-reset state: only ready_o is high.
        mid();
        check("rst ready_o", ready_o, 1);
        check("rst commit_ready_o", commit_ready_o, 0);
        check("rst result_valid_o", result_valid_o, 0);
        check("rst csr_addr_o", csr_addr_o, 0);
        check("rst commit_err_o", commit_err_o, 0);
        nxt();

        // Single push and writeback echo.
        drive(1, 3'd5, 12'h300, 8'h21, 64'hDEAD, 0, 0);
        mid();
        check("push ready_o", ready_o, 1);
        nxt();
        idle();
        mid();
        check("echo result_valid_o", result_valid_o, 1);
        check("echo result_trans_id_o", result_trans_id_o, 5);
        check("echo result_o", result_o, 64'hDEAD);
        check("echo commit_ready_o", commit_ready_o, 1);
        check("head csr_addr_o", csr_addr_o, 12'h300);
        check("head csr_op_o", csr_op_o, 8'h21);
        nxt();
        drive(0, '0, 12'h0, 8'h0, 64'h0, 1, 0);
        mid();
        check("commit1 csr_valid_o", csr_valid_o, 1);
        check("commit1 csr_addr_o", csr_addr_o, 12'h300);
        nxt();
        idle();
        mid();
        check("drained commit_ready_o", commit_ready_o, 0);
        check("one-shot result_valid_o", result_valid_o, 0);
        nxt();

        // Fill DEPTH=2, push refused when full even alongside commit.
        drive(1, 3'd1, 12'h341, 8'h01, 64'h1, 0, 0);
        nxt();
        drive(1, 3'd2, 12'h342, 8'h02, 64'h2, 0, 0);
        nxt();
        drive(1, 3'd3, 12'h343, 8'h03, 64'h3, 0, 0);
        mid();
        check("full ready_o", ready_o, 0);
        check("full head addr", csr_addr_o, 12'h341);
        nxt();
        drive(1, 3'd3, 12'h343, 8'h03, 64'h3, 1, 0);
        mid();
        check("full+commit ready_o", ready_o, 0);
        check("full+commit csr_valid_o", csr_valid_o, 1);
        check("full+commit csr_addr_o", csr_addr_o, 12'h341);
        nxt();
        idle();
        mid();
        check("after pop head addr", csr_addr_o, 12'h342);
        check("refused push result_valid_o", result_valid_o, 0);
`ifdef CSR_COMMIT_QUEUE_OCCUPANCY_EN
        check("count 2->1", occupancy_o, 1);
        check("high-water mark", max_occupancy_o, 2);
`endif
        nxt();
        drive(0, '0, 12'h0, 8'h0, 64'h0, 1, 0);
        mid();
        check("pop 0x342", csr_addr_o, 12'h342);
        nxt();

        // Five push/pop pairs: order preserved through pointer wrap.
        drive(1, 3'd0, 12'h100, 8'h10, 64'h100, 0, 0);
        nxt();
        for (int i = 1; i < 5; i++) begin
            drive(1, 3'(i), 12'(256 + i), 8'(i), 64'(i), 1, 0);
            mid();
            check("pair csr_valid_o", csr_valid_o, 1);
            check("pair csr_addr_o", csr_addr_o, 64'(256 + i - 1));
            nxt();
        end
        drive(0, '0, 12'h0, 8'h0, 64'h0, 1, 0);
        mid();
        check("pair last addr", csr_addr_o, 12'h104);
        nxt();
        idle();
        mid();
        check("pairs drained", commit_ready_o, 0);
        nxt();

        // Flush with a same-cycle commit.
        drive(1, 3'd6, 12'h3A0, 8'hA0, 64'hA0, 0, 0);
        nxt();
        drive(1, 3'd7, 12'h3A1, 8'hA1, 64'hA1, 0, 0);
        nxt();
        drive(0, '0, 12'h0, 8'h0, 64'h0, 1, 1);
        mid();
        check("flush csr_valid_o", csr_valid_o, 1);
        check("flush csr_addr_o", csr_addr_o, 12'h3A0);
        check("flush ready_o", ready_o, 0);
        nxt();
        idle();
        mid();
        check("post-flush commit_ready_o", commit_ready_o, 0);
        check("post-flush csr_addr_o", csr_addr_o, 0);
        nxt();

        // Commit on empty queue.
        drive(0, '0, 12'h0, 8'h0, 64'h0, 1, 0);
        mid();
        check("empty commit csr_valid_o", csr_valid_o, 0);
        nxt();
        idle();
        mid();
        check("commit_err_o pulse", commit_err_o, 1);
        nxt();
        mid();
        check("commit_err_o one cycle", commit_err_o, 0);
        nxt();

        // Reset overrides a concurrent push and commit.
        drive(1, 3'd4, 12'h555, 8'h55, 64'h55, 0, 0);
        nxt();
        drive(1, 3'd4, 12'h556, 8'h56, 64'h56, 1, 1);
        rst_i = 1'b1;
        mid();
        check("rst ready_o low", ready_o, 0);
        check("rst csr_valid_o low", csr_valid_o, 0);
        nxt();
        rst_i = 1'b0;
        idle();
        mid();
        check("rst cleared queue", commit_ready_o, 0);
        check("rst cleared result_valid_o", result_valid_o, 0);
        nxt();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 1) == 1,
                  TIDW'($urandom),
                  12'($urandom),
                  8'($urandom),
                  {$urandom, $urandom},
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0);
            nxt();
        end
        rst_i = 1'b0;
        idle();
        nxt();
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/csr_commit_queue.md
CSR_COMMIT_QUEUE -- requirements
Module: csr_commit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of buffered CSR instructions (legal values 1..8).
REQ-002 SHALL have parameter XLEN, default 64, meaning the operand and write-data width.
REQ-003 SHALL have parameter TRANS_ID_BITS, default 3, meaning the scoreboard transaction-id width.
REQ-004 SHALL have one clock, clk_i; reset rst_i is synchronous and active-high.
REQ-005 SHALL have ports, in order:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  discard all uncommitted entries.
- valid_i  in  1  issue presents a CSR instruction.
- ready_o  out  1  queue can accept an instruction.
- trans_id_i  in  TRANS_ID_BITS  scoreboard id.
- csr_addr_i  in  12  CSR address.
- csr_op_i  in  8  CSR operation code.
- operand_i  in  XLEN  write operand.
- result_valid_o  out  1  writeback of the accepted instruction.
- result_trans_id_o  out  TRANS_ID_BITS  id for writeback.
- result_o  out  XLEN  operand echoed for writeback.
- commit_i  in  1  commit stage retires the head CSR instruction.
- commit_ready_o  out  1  head entry valid.
- csr_valid_o  out  1  CSR file performs head operation this cycle.
- csr_addr_o  out  12  head CSR address.
- csr_op_o  out  8  head CSR operation.
- csr_wdata_o  out  XLEN  head operand.
- commit_err_o  out  1  one-cycle pulse: commit with empty queue.

Function
REQ-006 SHALL be a circular FIFO of DEPTH entries {addr, op, operand}, with read pointer, write pointer and count.
REQ-007 SHALL drive ready_o = (count < DEPTH) && !flush_i; ready_o SHALL NOT depend on commit_i.
REQ-008 SHALL push when valid_i && ready_o; the entry is visible at the head no earlier than the next cycle.
REQ-009 SHALL assert result_valid_o one cycle after a push, with the pushed trans_id and operand, for exactly one cycle.
REQ-010 SHALL drive commit_ready_o = (count != 0), combinationally from state.
REQ-011 SHALL drive csr_valid_o = commit_i && count != 0, combinationally (zero latency).
REQ-012 SHALL drive csr_addr_o, csr_op_o and csr_wdata_o from the head entry at all times, and 0 when empty.
REQ-013 SHALL pop the head in the same cycle csr_valid_o is high.
REQ-014 SHALL pulse commit_err_o one cycle after commit_i with count == 0; no state SHALL change.
REQ-015 SHALL allow a simultaneous push and pop when not full; count is then unchanged.
REQ-016 SHALL wrap pointers from DEPTH-1 to 0.
REQ-017 On flush_i, commit_i SHALL still take effect first (head presented to the CSR file). All entries SHALL then be cleared: count=0 and pointers=0 next cycle.
REQ-018 flush_i SHALL suppress a pending result_valid_o for the next cycle.

Reset
REQ-019 rst_i SHALL clear count, pointers, entry valid state, result_valid_o and commit_err_o to 0 at the next clk_i edge.
REQ-020 rst_i SHALL override flush_i, valid_i and commit_i; during reset csr_valid_o=0 and ready_o=0.
REQ-021 After reset all outputs SHALL be 0 except ready_o=1.

Configuration
REQ-022 With macro CSR_COMMIT_QUEUE_OCCUPANCY_EN defined, ports occupancy_o and max_occupancy_o SHALL be present, each $clog2(DEPTH+1) bits.
- occupancy_o is the count.
- max_occupancy_o is a sticky high-water mark, cleared only by rst_i.
REQ-023 Without the macro these ports and their registers SHALL be absent, and behaviour is otherwise identical.

Verification
REQ-024 Reset, then push addr 0x300, op 0x21, operand 0xDEAD, id 5 -> next cycle result_valid_o=1, result_trans_id_o=5, result_o=0xDEAD; commit_ready_o=1.
REQ-025 DEPTH=2: push 0x341 then 0x342; valid_i held -> ready_o=0; commit_i -> csr_valid_o=1 with csr_addr_o=0x341 same cycle, then head 0x342.
REQ-026 Full queue: commit_i and valid_i in the same cycle -> push refused; count goes 2->1.
REQ-027 Five push/pop pairs with DEPTH=2 -> addresses leave in order, pointers wrap, no loss.
REQ-028 Two entries plus flush_i and commit_i in the same cycle -> csr_valid_o=1 for the head, then count=0 and commit_ready_o=0.
REQ-029 commit_i with an empty queue -> csr_valid_o=0, then commit_err_o=1 for one cycle; with the macro on, max_occupancy_o=2 after REQ-025.
